// File: rtl/tlp_demux_n.sv
// tlp_demux_n: classifies each TLP at SOP by its fmt/type byte and steers the whole packet into a per-port 2-entry skid FIFO.
// Optional `TLP_DEMUX_STATS_EN adds pkt_cnt (per port) and drop_cnt saturating counters.
module tlp_demux_n #(
   parameter int PORTS          = 4,
   parameter int DOUBLE_WORD    = 32,
   parameter int HEADER_SIZE    = 4*DOUBLE_WORD,
   parameter int TLP_DATA_WIDTH = 8*DOUBLE_WORD,
   parameter logic [PORTS*8-1:0] MATCH_VAL  = {8'h4A, 8'h0A, 8'h60, 8'h20},
   parameter logic [PORTS*8-1:0] MATCH_MASK = {8'hFF, 8'hFF, 8'hDF, 8'hDF}
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            enable,
   input  logic [TLP_DATA_WIDTH-1:0]       in_data,
   input  logic [HEADER_SIZE-1:0]          in_hdr,
   input  logic                            in_sop,
   input  logic                            in_eop,
   input  logic                            in_valid,
   output logic                            in_ready,
   output logic [PORTS*TLP_DATA_WIDTH-1:0] out_data,
   output logic [PORTS*HEADER_SIZE-1:0]    out_hdr,
   output logic [PORTS-1:0]                out_sop,
   output logic [PORTS-1:0]                out_eop,
   output logic [PORTS-1:0]                out_valid,
   input  logic [PORTS-1:0]                out_ready,
   output logic                            frame_err
`ifdef TLP_DEMUX_STATS_EN
   ,
   output logic [PORTS*16-1:0]             pkt_cnt,
   output logic [15:0]                     drop_cnt
`endif
);
   localparam int RW = (PORTS > 1) ? $clog2(PORTS) : 1;
   localparam int EW = TLP_DATA_WIDTH + HEADER_SIZE + 2;

   typedef enum logic [1:0] {ST_IDLE, ST_PKT, ST_DROP} state_t;

   state_t          state_q, state_d;
   logic [RW-1:0]   route_q, route_d;
   logic            frame_err_q, frame_err_d;
   logic [7:0]      ft;
   logic [PORTS-1:0] hit, full;
   logic            dec_hit, new_ok, fire, push_en, drop_pkt;
   logic [RW-1:0]   dec_port, push_port;
   logic [EW-1:0]   in_ent;

   assign ft     = in_hdr[HEADER_SIZE-1 -: 8];
   assign in_ent = {in_data, in_hdr, in_sop, in_eop};

   // Lowest-index matching rule wins.
   always_comb begin
      dec_hit  = 1'b0;
      dec_port = '0;
      for (int p = PORTS-1; p >= 0; p--) begin
         if (hit[p]) begin
            dec_hit  = 1'b1;
            dec_port = RW'(p);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      route_d     = route_q;
      frame_err_d = 1'b0;
      push_en     = 1'b0;
      push_port   = route_q;
      drop_pkt    = 1'b0;
      new_ok      = !dec_hit || !full[dec_port];
      // A SOP arriving mid-packet is steered by its own decode, so it is gated by its own destination.
      case (state_q)
         ST_IDLE: in_ready = enable && (!in_sop || new_ok);
         default: in_ready = in_sop ? new_ok : ((state_q == ST_DROP) || !full[route_q]);
      endcase
      if (rst) in_ready = 1'b0;
      fire = in_valid && in_ready;
      if (fire) begin
         if (in_sop) begin
            frame_err_d = (state_q != ST_IDLE);
            if (dec_hit) begin
               push_en   = 1'b1;
               push_port = dec_port;
               route_d   = dec_port;
               state_d   = ST_PKT;
            end else begin
               drop_pkt = 1'b1;
               state_d  = ST_DROP;
            end
            if (in_eop) state_d = ST_IDLE;
         end else if (state_q == ST_IDLE) begin
            frame_err_d = 1'b1;
         end else begin
            push_en = (state_q == ST_PKT);
            if (in_eop) state_d = ST_IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         route_q     <= '0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         route_q     <= route_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign frame_err = frame_err_q;

   genvar gi;
   generate
      for (gi = 0; gi < PORTS; gi++) begin : g_port
         logic [EW-1:0] head_q, head_d, tail_q, tail_d;
         logic [1:0]    cnt_q, cnt_d;
         logic          push, pop;

         assign hit[gi]  = ((ft & MATCH_MASK[gi*8 +: 8]) == (MATCH_VAL[gi*8 +: 8] & MATCH_MASK[gi*8 +: 8]));
         assign push     = push_en && (push_port == RW'(gi));
         assign pop      = (cnt_q != 2'd0) && out_ready[gi];
         assign full[gi] = (cnt_q == 2'd2);

         // Head register always feeds the outputs; tail only holds the second entry.
         always_comb begin
            cnt_d  = cnt_q;
            head_d = head_q;
            tail_d = tail_q;
            case ({push, pop})
               2'b10: begin
                  if (cnt_q == 2'd0) head_d = in_ent;
                  else               tail_d = in_ent;
                  cnt_d = cnt_q + 2'd1;
               end
               2'b01: begin
                  if (cnt_q == 2'd2) head_d = tail_q;
                  cnt_d = cnt_q - 2'd1;
               end
               2'b11: head_d = in_ent;
               default: ;
            endcase
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               cnt_q  <= 2'd0;
               head_q <= '0;
               tail_q <= '0;
            end else begin
               cnt_q  <= cnt_d;
               head_q <= head_d;
               tail_q <= tail_d;
            end
         end

         assign out_valid[gi] = (cnt_q != 2'd0);
         assign {out_data[gi*TLP_DATA_WIDTH +: TLP_DATA_WIDTH], out_hdr[gi*HEADER_SIZE +: HEADER_SIZE],
                 out_sop[gi], out_eop[gi]} = head_q;

`ifdef TLP_DEMUX_STATS_EN
         logic [15:0] pkt_cnt_q, pkt_cnt_d;
         always_comb begin
            pkt_cnt_d = pkt_cnt_q;
            if (push && in_eop && (pkt_cnt_q != 16'hFFFF)) pkt_cnt_d = pkt_cnt_q + 16'd1;
         end
         always_ff @(posedge clk) begin
            if (rst) pkt_cnt_q <= 16'd0;
            else     pkt_cnt_q <= pkt_cnt_d;
         end
         assign pkt_cnt[gi*16 +: 16] = pkt_cnt_q;
`endif
      end
   endgenerate

`ifdef TLP_DEMUX_STATS_EN
   logic [15:0] drop_cnt_q, drop_cnt_d;
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if ((drop_pkt || frame_err_d) && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
   end
   always_ff @(posedge clk) begin
      if (rst) drop_cnt_q <= 16'd0;
      else     drop_cnt_q <= drop_cnt_d;
   end
   assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_tlp_demux_n.sv
// Directed self-checking bench for tlp_demux_n (default rules: 20/60 masked DF -> ports 0/1, 0A -> 2, 4A -> 3).
module tb_tlp_demux_n;
   localparam int P  = 4;
   localparam int DW = 256;
   localparam int HW = 128;

   logic            clk = 1'b0;
   logic            rst, enable;
   logic [DW-1:0]   in_data;
   logic [HW-1:0]   in_hdr;
   logic            in_sop, in_eop, in_valid, in_ready;
   logic [P*DW-1:0] out_data;
   logic [P*HW-1:0] out_hdr;
   logic [P-1:0]    out_sop, out_eop, out_valid, out_ready;
   logic            frame_err;
`ifdef TLP_DEMUX_STATS_EN
   logic [P*16-1:0] pkt_cnt;
   logic [15:0]     drop_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   tlp_demux_n dut (
      .clk(clk), .rst(rst), .enable(enable),
      .in_data(in_data), .in_hdr(in_hdr), .in_sop(in_sop), .in_eop(in_eop),
      .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_hdr(out_hdr), .out_sop(out_sop), .out_eop(out_eop),
      .out_valid(out_valid), .out_ready(out_ready), .frame_err(frame_err)
`ifdef TLP_DEMUX_STATS_EN
      , .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
`endif
   );

   function automatic logic [DW-1:0] dat(input logic [31:0] t);
      return {8{t}};
   endfunction

   task automatic drive(input logic v, input logic s, input logic e, input logic [7:0] ft, input logic [31:0] t);
      in_valid = v;
      in_sop   = s;
      in_eop   = e;
      in_hdr   = {ft, 88'h0, t};
      in_data  = {8{t}};
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      drive(1'b1, 1'b1, 1'b1, 8'h20, 32'h1);
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      checks++; if (out_valid !== 4'b0000) begin failures++; $display("FAIL reset_valid got=%b exp=0000", out_valid); end
      checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
      checks++; if (out_data !== '0 || out_sop !== '0 || out_eop !== '0) begin failures++; $display("FAIL reset_payload got_sop=%b got_eop=%b exp=0", out_sop, out_eop); end
      @(posedge clk); @(negedge clk);
      checks++; if (out_valid !== 4'b0000) begin failures++; $display("FAIL reset_no_push got=%b exp=0000", out_valid); end
      drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
      rst = 1'b0;
      $display("txn reset released");
   endtask

   task automatic test_single;
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b1, 8'h20, 32'hA0);
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", in_ready); end
      @(posedge clk); @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
      checks++; if (out_valid !== 4'b0001) begin failures++; $display("FAIL single_valid got=%b exp=0001", out_valid); end
      checks++; if (out_data[0 +: DW] !== dat(32'hA0)) begin failures++; $display("FAIL single_data got=%h exp=%h", out_data[31:0], 32'hA0); end
      checks++; if ({out_sop[0], out_eop[0]} !== 2'b11) begin failures++; $display("FAIL single_sop_eop got=%b exp=11", {out_sop[0], out_eop[0]}); end
      checks++; if (out_hdr[HW-1 -: 8] !== 8'h20) begin failures++; $display("FAIL single_hdr got=%h exp=20", out_hdr[HW-1 -: 8]); end
      @(negedge clk);
      checks++; if (out_valid !== 4'b0000) begin failures++; $display("FAIL single_drain got=%b exp=0000", out_valid); end
      $display("txn single ft=20 -> port0");
   endtask

   task automatic test_stall;
      @(negedge clk);
      out_ready = 4'b1101;
      drive(1'b1, 1'b1, 1'b0, 8'h60, 32'hB1);
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_ready_b1 got=%b exp=1", in_ready); end
      @(posedge clk); @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, 8'h60, 32'hB2);
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_ready_b2 got=%b exp=1", in_ready); end
      @(posedge clk); @(negedge clk);
      drive(1'b1, 1'b0, 1'b1, 8'h60, 32'hB3);
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_ready_b3_full got=%b exp=0", in_ready); end
      checks++; if (out_valid !== 4'b0010) begin failures++; $display("FAIL stall_valid got=%b exp=0010", out_valid); end
      checks++; if (out_data[1*DW +: DW] !== dat(32'hB1)) begin failures++; $display("FAIL stall_head_b1 got=%h exp=%h", out_data[1*DW +: 32], 32'hB1); end
      @(posedge clk); @(negedge clk);
      checks++; if (out_data[1*DW +: DW] !== dat(32'hB1)) begin failures++; $display("FAIL stall_stable got=%h exp=%h", out_data[1*DW +: 32], 32'hB1); end
      out_ready = 4'b1111;
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_no_push_pop_full got=%b exp=0", in_ready); end
      @(posedge clk); @(negedge clk);
      checks++; if (out_data[1*DW +: DW] !== dat(32'hB2)) begin failures++; $display("FAIL stall_head_b2 got=%h exp=%h", out_data[1*DW +: 32], 32'hB2); end
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_ready_b3 got=%b exp=1", in_ready); end
      @(posedge clk); @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
      checks++; if (out_data[1*DW +: DW] !== dat(32'hB3) || out_eop[1] !== 1'b1) begin failures++; $display("FAIL stall_head_b3 got=%h eop=%b exp=%h eop=1", out_data[1*DW +: 32], out_eop[1], 32'hB3); end
      @(negedge clk);
      checks++; if (out_valid !== 4'b0000) begin failures++; $display("FAIL stall_drain got=%b exp=0000", out_valid); end
      $display("txn stall ft=60 3 beats -> port1");
   endtask

   task automatic test_back_to_back;
      @(negedge clk);
      out_ready = 4'b0111;
      drive(1'b1, 1'b1, 1'b1, 8'h4A, 32'hC0);
      @(posedge clk); @(negedge clk);
      drive(1'b1, 1'b1, 1'b0, 8'h0A, 32'hC1);
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_c1 got=%b exp=1", in_ready); end
      checks++; if (out_valid !== 4'b1000 || out_data[3*DW +: DW] !== dat(32'hC0)) begin failures++; $display("FAIL b2b_port3 got_valid=%b got=%h exp_valid=1000 exp=%h", out_valid, out_data[3*DW +: 32], 32'hC0); end
      @(posedge clk); @(negedge clk);
      drive(1'b1, 1'b0, 1'b1, 8'h0A, 32'hC2);
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_c2 got=%b exp=1", in_ready); end
      checks++; if (out_valid !== 4'b1100 || out_data[2*DW +: DW] !== dat(32'hC1)) begin failures++; $display("FAIL b2b_port2_c1 got_valid=%b got=%h exp_valid=1100 exp=%h", out_valid, out_data[2*DW +: 32], 32'hC1); end
      @(posedge clk); @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
      checks++; if (out_data[2*DW +: DW] !== dat(32'hC2) || out_eop[2] !== 1'b1) begin failures++; $display("FAIL b2b_port2_c2 got=%h eop=%b exp=%h eop=1", out_data[2*DW +: 32], out_eop[2], 32'hC2); end
      checks++; if (out_valid !== 4'b1100 || out_data[3*DW +: DW] !== dat(32'hC0)) begin failures++; $display("FAIL b2b_port3_held got_valid=%b got=%h exp_valid=1100 exp=%h", out_valid, out_data[3*DW +: 32], 32'hC0); end
      out_ready = 4'b1111;
      @(negedge clk);
      checks++; if (out_valid !== 4'b0000) begin failures++; $display("FAIL b2b_drain got=%b exp=0000", out_valid); end
      $display("txn back_to_back ft=4A -> port3, ft=0A -> port2");
   endtask

   task automatic test_drop;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive(1'b1, (i == 0), (i == 3), 8'hFF, 32'(32'hD0 + i));
         #1;
         checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL drop_ready beat=%0d got=%b exp=1", i, in_ready); end
         checks++; if (out_valid !== 4'b0000) begin failures++; $display("FAIL drop_valid beat=%0d got=%b exp=0000", i, out_valid); end
         @(posedge clk);
      end
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
      checks++; if (out_valid !== 4'b0000 || frame_err !== 1'b0) begin failures++; $display("FAIL drop_after got_valid=%b got_err=%b exp=0000/0", out_valid, frame_err); end
`ifdef TLP_DEMUX_STATS_EN
      checks++; if (drop_cnt !== 16'd1) begin failures++; $display("FAIL drop_cnt got=%0d exp=1", drop_cnt); end
`endif
      $display("txn drop ft=FF 4 beats");
   endtask

   task automatic test_frame;
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, 8'h20, 32'hE0);
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL frame_nosop_ready got=%b exp=1", in_ready); end
      @(posedge clk); @(negedge clk);
      drive(1'b1, 1'b1, 1'b0, 8'h20, 32'hE1);
      checks++; if (frame_err !== 1'b1 || out_valid !== 4'b0000) begin failures++; $display("FAIL frame_nosop got_err=%b got_valid=%b exp=1/0000", frame_err, out_valid); end
      @(posedge clk); @(negedge clk);
      drive(1'b1, 1'b1, 1'b1, 8'h60, 32'hE2);
      checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL frame_pulse_width got=%b exp=0", frame_err); end
      checks++; if (out_valid !== 4'b0001 || out_data[0 +: DW] !== dat(32'hE1) || out_eop[0] !== 1'b0) begin failures++; $display("FAIL frame_e1 got_valid=%b got=%h eop=%b exp=0001 %h eop=0", out_valid, out_data[31:0], out_eop[0], 32'hE1); end
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL frame_midsop_ready got=%b exp=1", in_ready); end
      @(posedge clk); @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
      checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL frame_midsop_err got=%b exp=1", frame_err); end
      checks++; if (out_valid !== 4'b0010 || out_data[1*DW +: DW] !== dat(32'hE2) || {out_sop[1], out_eop[1]} !== 2'b11) begin failures++; $display("FAIL frame_reroute got_valid=%b got=%h exp=0010 %h", out_valid, out_data[1*DW +: 32], 32'hE2); end
      @(negedge clk);
      checks++; if (frame_err !== 1'b0 || out_valid !== 4'b0000) begin failures++; $display("FAIL frame_quiet got_err=%b got_valid=%b exp=0/0000", frame_err, out_valid); end
      $display("txn frame errors: no-SOP beat, SOP mid-packet -> port1");
   endtask

   task automatic test_enable;
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b0, 8'h20, 32'hF0);
      @(posedge clk); @(negedge clk);
      enable = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 8'h20, 32'hF1);
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL enable_mid_ready got=%b exp=1", in_ready); end
      @(posedge clk); @(negedge clk);
      drive(1'b1, 1'b0, 1'b1, 8'h20, 32'hF2);
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL enable_eop_ready got=%b exp=1", in_ready); end
      @(posedge clk); @(negedge clk);
      drive(1'b1, 1'b1, 1'b1, 8'h0A, 32'hF3);
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL enable_hold_ready got=%b exp=0", in_ready); end
      checks++; if (out_valid !== 4'b0001 || out_data[0 +: DW] !== dat(32'hF2) || out_eop[0] !== 1'b1) begin failures++; $display("FAIL enable_complete got_valid=%b got=%h exp=0001 %h", out_valid, out_data[31:0], 32'hF2); end
      @(posedge clk); @(negedge clk);
      checks++; if (out_valid !== 4'b0000) begin failures++; $display("FAIL enable_held_valid got=%b exp=0000", out_valid); end
      enable = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL enable_resume_ready got=%b exp=1", in_ready); end
      @(posedge clk); @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
      checks++; if (out_valid !== 4'b0100 || out_data[2*DW +: DW] !== dat(32'hF3)) begin failures++; $display("FAIL enable_resume got_valid=%b got=%h exp=0100 %h", out_valid, out_data[2*DW +: 32], 32'hF3); end
      @(negedge clk);
      $display("txn enable gating ft=20 then ft=0A -> port2");
   endtask

   task automatic test_rst_mid;
      @(negedge clk);
      out_ready = 4'b1101;
      drive(1'b1, 1'b1, 1'b0, 8'h60, 32'h51);
      @(posedge clk); @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, 8'h60, 32'h52);
      @(posedge clk); @(negedge clk);
      checks++; if (out_valid !== 4'b0010) begin failures++; $display("FAIL rstmid_pre got=%b exp=0010", out_valid); end
      rst = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 8'h60, 32'h53);
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rstmid_ready got=%b exp=0", in_ready); end
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      checks++; if (out_valid !== 4'b0000 || out_data !== '0) begin failures++; $display("FAIL rstmid_flush got=%b exp=0000", out_valid); end
      drive(1'b1, 1'b0, 1'b1, 8'h60, 32'h54);
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_after_ready got=%b exp=1", in_ready); end
      @(posedge clk); @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
      checks++; if (frame_err !== 1'b1 || out_valid !== 4'b0000) begin failures++; $display("FAIL rstmid_orphan got_err=%b got_valid=%b exp=1/0000", frame_err, out_valid); end
      out_ready = 4'b1111;
      @(negedge clk);
      $display("txn reset mid-packet, orphan beat dropped");
   endtask

   initial begin
      rst       = 1'b1;
      enable    = 1'b1;
      out_ready = 4'b1111;
      drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
      test_reset;
      test_single;
      test_stall;
      test_back_to_back;
      test_drop;
      test_frame;
      test_enable;
      test_rst_mid;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
